// File: rtl/dma_axi_rd_stream.sv
// AXI4 read DMA: moves xfer_len words starting at start_addr into a
// first-word-fall-through FIFO drained by a ready/valid stream. Bursts are
// INCR, at most MAX_BURST beats, never cross a 4KB page, and are only
// requested once the FIFO has room for the whole burst.
module dma_axi_rd_stream #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 16,
    parameter int FIFO_AW   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  xfer_len,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [3:0]        m_axi_arid,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arlock,
    output logic [3:0]        m_axi_arcache,
    output logic [2:0]        m_axi_arprot,
    output logic [3:0]        m_axi_arqos,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int BSHIFT = $clog2(DATA_W / 8);
    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int BW     = $clog2(MAX_BURST) + 1;
    localparam int CW     = ((LEN_W > 13) ? LEN_W : 13) + 2;
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(DATA_W / 8 - 1);

    typedef enum logic [2:0] {IDLE, SPACE, ADDR, DATA, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q;
    logic [LEN_W-1:0]     remain_q;
    logic [BW-1:0]        burst_q;
    logic [BW-1:0]        beat_cnt_q;
    logic [ADDR_W-1:0]    araddr_q;
    logic [7:0]           arlen_q;
    logic                 error_q;
    logic                 done_q;
    logic                 rready_w;

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]     cnt_q;
    logic                 push, pop;

    logic [12:0]          bytes_to_4k;
    logic [CW-1:0]        remain_w, bound_w, beats_w, free_w;
    logic                 space_ok, burst_end, last_burst;

    // rlast is deliberately ignored (beat counter ends the burst); rresp[0] carries no meaning here
    logic unused_ok;
    assign unused_ok = ^{m_axi_rlast, m_axi_rresp[0]};

    assign bytes_to_4k = 13'h1000 - {1'b0, addr_q[11:0]};
    assign remain_w    = CW'(remain_q);
    assign bound_w     = CW'(bytes_to_4k >> BSHIFT);
    assign free_w      = CW'(DEPTH) - CW'(cnt_q);
    assign space_ok    = free_w >= beats_w;
    assign push        = m_axi_rvalid && rready_w;
    assign pop         = out_valid && out_ready;
    assign burst_end   = push && (beat_cnt_q == burst_q - BW'(1));
    assign last_burst  = remain_w == CW'(burst_q);

    // Burst size: smallest of words left, burst cap and words to the page end
    always_comb begin
        beats_w = remain_w;
        if (CW'(MAX_BURST) < beats_w) beats_w = CW'(MAX_BURST);
        if (bound_w < beats_w)        beats_w = bound_w;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && xfer_len != '0) state_d = SPACE;
            SPACE:   if (space_ok) state_d = ADDR;
            ADDR:    if (m_axi_arready) state_d = DATA;
            DATA:    if (burst_end) state_d = last_burst ? DRAIN : SPACE;
            DRAIN:   if (cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy          = 1'b1;
        m_axi_arvalid = 1'b0;
        rready_w      = 1'b0;
        case (state_q)
            IDLE:    busy = 1'b0;
            ADDR:    m_axi_arvalid = 1'b1;
            DATA:    rready_w = 1'b1;
            default: ;
        endcase
    end

    // Transfer bookkeeping: address/length progress, AR fields, status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            remain_q   <= '0;
            burst_q    <= '0;
            beat_cnt_q <= '0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            error_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    addr_q   <= start_addr & ~LOW_MASK;
                    remain_q <= xfer_len;
                    error_q  <= 1'b0;
                    if (xfer_len == '0) done_q <= 1'b1;
                end
                SPACE: if (space_ok) begin
                    araddr_q   <= addr_q;
                    arlen_q    <= 8'(beats_w - CW'(1));
                    burst_q    <= BW'(beats_w);
                    beat_cnt_q <= '0;
                end
                DATA: if (push) begin
                    beat_cnt_q <= beat_cnt_q + BW'(1);
                    if (m_axi_rresp[1]) error_q <= 1'b1;
                    if (burst_end) begin
                        remain_q <= remain_q - LEN_W'(burst_q);
                        addr_q   <= addr_q + (ADDR_W'(burst_q) << BSHIFT);
                    end
                end
                DRAIN: if (cnt_q == '0) done_q <= 1'b1;
                default: ;
            endcase
        end
    end

    // FIFO storage (no reset needed, validity tracked by the pointers)
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= m_axi_rdata;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (FIFO_AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (FIFO_AW+1)'(1);
                default: ;
            endcase
        end
    end

    assign out_data      = mem[rd_ptr_q];
    assign out_valid     = cnt_q != '0;
    assign m_axi_rready  = rready_w;
    assign done          = done_q;
    assign error         = error_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arid    = 4'h0;
    assign m_axi_arsize  = 3'(BSHIFT);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b010;
    assign m_axi_arqos   = 4'h0;
endmodule

// File: tb/tb_dma_axi_rd_stream.sv
// Bench for dma_axi_rd_stream: an AXI read slave model, a stream monitor and
// a done monitor check against queues filled when each command is issued.
`timescale 1ns/1ps
module tb_dma_axi_rd_stream;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] start_addr = '0;
    logic [15:0] xfer_len = '0;
    logic        busy, done, error;
    logic [3:0]  m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic [3:0]  m_axi_arqos;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    always #5 clk = ~clk;

    dma_axi_rd_stream dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .xfer_len(xfer_len), .busy(busy), .done(done), .error(error),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    typedef struct {logic [31:0] addr; logic [7:0] len;} ar_t;
    ar_t         exp_ar[$];
    logic [31:0] exp_data[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ar_cnt = 0, done_cnt = 0, done_edge = 0, last_pop_edge = 0;
    int beat_no = 0, err_at = -1, ready_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fdata(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end else
            $display("ok   %s = %0h", nm, act);
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_error"}, error, 0);
        chk({nm, "_arvalid"}, m_axi_arvalid, 0);
        chk({nm, "_rready"}, m_axi_rready, 0);
        chk({nm, "_out_valid"}, out_valid, 0);
        chk({nm, "_araddr"}, m_axi_araddr, 0);
        chk({nm, "_arlen"}, m_axi_arlen, 0);
    endtask

    task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
        ar_t e;
        e.addr = a;
        e.len  = l;
        exp_ar.push_back(e);
    endtask

    task automatic start_xfer(input logic [31:0] a, input logic [15:0] n);
        ar_cnt   = 0;
        done_cnt = 0;
        beat_no  = 0;
        for (int i = 0; i < int'(n); i++) exp_data.push_back(fdata(a + 32'(i * 4)));
        start_addr = a;
        xfer_len   = n;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (done_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done, want done within %0d cycles", nm, budget);
        end
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_done_count"}, done_cnt, 1);
        chk({nm, "_busy_after"}, busy, 0);
        chk({nm, "_words_left"}, exp_data.size(), 0);
        chk({nm, "_ars_left"}, exp_ar.size(), 0);
    endtask

    // Stream monitor: a word is consumed at the next rising edge
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_data.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stray_word: got %0h, want no word", out_data);
            end else begin
                chk("stream_word", out_data, exp_data.pop_front());
            end
            last_pop_edge = cyc + 1;
        end
    end

    // Done monitor: busy must fall in the same cycle done pulses
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            done_edge = cyc;
            chk("busy_at_done", busy, 0);
        end
    end

    // AXI read slave plus stream-ready driver; acts just after each rising edge
    initial begin
        logic        ar_fire_s, r_fire_s;
        logic [31:0] ar_addr_s, raddr;
        logic [7:0]  ar_len_s;
        int          beats_left;
        ar_t         e;
        beats_left = 0;
        raddr = '0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        out_ready     = 1'b1;
        forever begin
            @(negedge clk);
            ar_fire_s = m_axi_arvalid && m_axi_arready;
            r_fire_s  = m_axi_rvalid && m_axi_rready;
            ar_addr_s = m_axi_araddr;
            ar_len_s  = m_axi_arlen;
            @(posedge clk); #1;
            if (!rst_n) begin
                beats_left = 0;
            end else begin
                if (ar_fire_s) begin
                    ar_cnt++;
                    chk("ar_attr", {m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock,
                                    m_axi_arcache, m_axi_arprot, m_axi_arqos},
                        {4'h0, 3'd2, 2'b01, 1'b0, 4'h3, 3'b010, 4'h0});
                    if (exp_ar.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL stray_ar: got addr %0h len %0d, want none", ar_addr_s, ar_len_s);
                    end else begin
                        e = exp_ar.pop_front();
                        chk("ar_addr", ar_addr_s, e.addr);
                        chk("ar_len", ar_len_s, e.len);
                    end
                    raddr      = ar_addr_s;
                    beats_left = int'(ar_len_s) + 1;
                end
                if (r_fire_s) begin
                    beats_left--;
                    raddr = raddr + 32'd4;
                    beat_no++;
                end
            end
            m_axi_arready = (cyc % 3) != 1;
            m_axi_rvalid  = (beats_left > 0) && ((cyc % 7) != 5);
            m_axi_rdata   = fdata(raddr);
            m_axi_rlast   = beats_left == 1;
            m_axi_rresp   = (beat_no == err_at) ? 2'b10 : 2'b00;
            out_ready     = (ready_mode == 0) ? 1'b1 :
                            (ready_mode == 1) ? 1'b0 : ((cyc % 4) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        int k;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single short burst, start latency, done one cycle after last pop
        ready_mode = 0;
        push_ar(32'h1000, 8'd3);
        start_xfer(32'h1000, 16'd4);
        chk("t1_busy_after_start", busy, 1);
        chk("t1_arvalid_not_yet", m_axi_arvalid, 0);
        wait_done("t1", 500);
        chk("t1_done_latency", done_edge, last_pop_edge + 1);

        // 2: 40 words in 16/16/8 bursts with a bursty consumer
        ready_mode = 2;
        push_ar(32'h0000, 8'd15);
        push_ar(32'h0040, 8'd15);
        push_ar(32'h0080, 8'd7);
        start_xfer(32'h0000, 16'd40);
        wait_done("t2", 2000);
        chk("t2_error", error, 0);

        // 3: split at the 4KB page boundary
        ready_mode = 0;
        push_ar(32'h0FF8, 8'd1);
        push_ar(32'h1000, 8'd5);
        start_xfer(32'h0FF8, 16'd8);
        wait_done("t3", 1000);

        // 4: stalled consumer limits issue to what the FIFO can hold
        ready_mode = 1;
        push_ar(32'h2000, 8'd15);
        push_ar(32'h2040, 8'd15);
        push_ar(32'h2080, 8'd15);
        push_ar(32'h20C0, 8'd15);
        start_xfer(32'h2000, 16'd64);
        repeat (150) @(posedge clk);
        #1;
        chk("t4_ars_while_stalled", ar_cnt, 2);
        chk("t4_arvalid_stalled", m_axi_arvalid, 0);
        chk("t4_out_valid_stalled", out_valid, 1);
        chk("t4_busy_stalled", busy, 1);
        ready_mode = 0;
        wait_done("t4", 2000);

        // 5: SLVERR on third beat, then sticky error cleared by a zero-length start
        err_at = 2;
        push_ar(32'h3000, 8'd7);
        start_xfer(32'h3000, 16'd8);
        wait_done("t5", 1000);
        chk("t5_error_set", error, 1);
        err_at = -1;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_error_sticky", error, 1);
        start_xfer(32'h3000, 16'd0);
        chk("t5_len0_done", done, 1);
        chk("t5_len0_busy", busy, 0);
        chk("t5_error_cleared", error, 0);
        @(posedge clk); #1;
        chk("t5_len0_done_pulse", done, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("t5_len0_no_ar", ar_cnt, 0);
        chk("t5_len0_done_count", done_cnt, 1);

        // 6: asynchronous reset in the middle of a data phase, then a clean rerun
        push_ar(32'h4000, 8'd15);
        push_ar(32'h4040, 8'd15);
        push_ar(32'h4080, 8'd7);
        start_xfer(32'h4000, 16'd40);
        k = 0;
        while (beat_no < 5 && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        chk("t6_reached_data", beat_no >= 5, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("t6_rst");
        exp_ar.delete();
        exp_data.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        push_ar(32'h1000, 8'd3);
        start_xfer(32'h1000, 16'd4);
        wait_done("t6_rerun", 500);
        chk("t6_rerun_error", error, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
